// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: debounced set/reset requests turned into non-overlapping S/R latch pulses.
module sr_drive_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int GAP_CYCLES      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic reset_in,
  output logic s,
  output logic r,
  output logic q_exp,
  output logic busy,
  output logic conflict
);
  typedef enum logic [2:0] {INIT, IDLE, SET_P, RST_P, GAP} state_t;
  state_t state, state_n;
  logic [1:0] sync1, sync2, deb, deb_d, pend, clr;
  logic [7:0] dcnt [2];
  logic [3:0] cnt, cnt_n;
  logic q_n, conf_n;
  logic pend_set, pend_rst;
  assign pend_set = pend[0];
  assign pend_rst = pend[1];
  // bit 0 carries the set channel, bit 1 the reset channel
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb <= '0;
      deb_d <= '0;
      pend <= '0;
      dcnt <= '{default: '0};
    end else begin
      sync1 <= {reset_in, set_in};
      sync2 <= sync1;
      deb_d <= deb;
      pend <= (pend & ~clr) | (deb & ~deb_d);
      for (int i = 0; i < 2; i++)
        if (sync2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 8'd1;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = '0;
    q_n = q_exp;
    conf_n = 1'b0;
    clr = '0;
    case (state)
      INIT: if (r && cnt == 4'(PULSE_CYCLES - 1)) state_n = GAP;
            else cnt_n = r ? cnt + 4'd1 : 4'd0;
      IDLE: if (&pend) begin
              state_n = RST_P;
              clr = 2'b11;
              conf_n = 1'b1;
            end else if (pend[0]) begin
              clr = 2'b01;
              state_n = q_exp ? IDLE : SET_P;
            end else if (pend[1]) begin
              clr = 2'b10;
              state_n = q_exp ? RST_P : IDLE;
            end
      SET_P, RST_P: if (cnt == 4'(PULSE_CYCLES - 1)) begin
              state_n = GAP;
              q_n = (state == SET_P);
            end else cnt_n = cnt + 4'd1;
      GAP: if (cnt == 4'(GAP_CYCLES - 1)) state_n = IDLE;
           else cnt_n = cnt + 4'd1;
      default: state_n = INIT;
    endcase
  end
  // outputs registered from the next state so s/r/busy change with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      s <= 1'b0;
      r <= 1'b0;
      q_exp <= 1'b0;
      busy <= 1'b1;
      conflict <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      s <= (state_n == SET_P);
      r <= (state_n == RST_P) || (state_n == INIT);
      q_exp <= q_n;
      busy <= (state_n != IDLE);
      conflict <= conf_n;
    end
  end
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed scenario bench for sr_drive_ctrl with default parameters.
module tb_sr_drive_ctrl;
  logic clk = 1'b0, rst = 1'b1, set_in = 1'b0, reset_in = 1'b0;
  logic s, r, q_exp, busy, conflict;
  int passed = 0, total = 0;
  logic sv [1:24], rv [1:24], qv [1:24], cv [1:24], bv [1:24];

  sr_drive_ctrl dut (.clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
    .s(s), .r(r), .q_exp(q_exp), .busy(busy), .conflict(conflict));

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic record(input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      sv[i] = s; rv[i] = r; qv[i] = q_exp; cv[i] = conflict; bv[i] = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    total++; if (s !== 1'b0) $display("FAIL reset_s got %b want 0", s); else passed++;
    total++; if (r !== 1'b0) $display("FAIL reset_r got %b want 0", r); else passed++;
    total++; if (q_exp !== 1'b0) $display("FAIL reset_q got %b want 0", q_exp); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else passed++;
    total++; if (conflict !== 1'b0) $display("FAIL reset_conflict got %b want 0", conflict); else passed++;
  endtask

  task automatic test_init();
    rst = 1'b0;
    record(4);
    total++; if ({rv[1], rv[2], rv[3]} !== 3'b110) $display("FAIL init_r got %b%b%b want 110", rv[1], rv[2], rv[3]); else passed++;
    total++; if ({bv[3], bv[4]} !== 2'b10) $display("FAIL init_busy got %b%b want 10", bv[3], bv[4]); else passed++;
    total++; if (qv[4] !== 1'b0) $display("FAIL init_q got %b want 0", qv[4]); else passed++;
  endtask

  task automatic test_glitch();
    int sc = 0, pc = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 10) set_in = ~set_in;
      else set_in = 1'b0;
      step();
      sc += int'(s);
      pc += int'(dut.pend_set);
    end
    total++; if (sc !== 0) $display("FAIL glitch_s got %0d want 0", sc); else passed++;
    total++; if (pc !== 0) $display("FAIL glitch_pend got %0d want 0", pc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_set();
    int rc = 0;
    set_in = 1'b1;
    record(12);
    for (int i = 1; i <= 12; i++) rc += int'(rv[i]);
    total++; if (sv[7] !== 1'b0) $display("FAIL set_early got %b want 0", sv[7]); else passed++;
    total++; if ({sv[8], sv[9], sv[10]} !== 3'b110) $display("FAIL set_pulse got %b%b%b want 110", sv[8], sv[9], sv[10]); else passed++;
    total++; if ({qv[9], qv[10]} !== 2'b01) $display("FAIL set_q got %b%b want 01", qv[9], qv[10]); else passed++;
    total++; if ({bv[10], bv[11]} !== 2'b10) $display("FAIL set_busy got %b%b want 10", bv[10], bv[11]); else passed++;
    total++; if (rc !== 0) $display("FAIL set_r got %0d want 0", rc); else passed++;
    set_in = 1'b0;
    record(12);
    rc = 0;
    for (int i = 1; i <= 12; i++) rc += int'(sv[i]) + int'(rv[i]);
    total++; if (rc !== 0 || q_exp !== 1'b1) $display("FAIL set_fall got pulses=%0d q=%b want 0 1", rc, q_exp); else passed++;
  endtask

  task automatic test_conflict();
    int sc = 0, cc = 0;
    set_in = 1'b1;
    reset_in = 1'b1;
    record(14);
    for (int i = 1; i <= 14; i++) begin
      sc += int'(sv[i]);
      cc += int'(cv[i]);
    end
    total++; if ({rv[7], rv[8], rv[9], rv[10]} !== 4'b0110) $display("FAIL conf_r got %b%b%b%b want 0110", rv[7], rv[8], rv[9], rv[10]); else passed++;
    total++; if (cv[8] !== 1'b1 || cc !== 1) $display("FAIL conf_flag got %b count=%0d want 1 1", cv[8], cc); else passed++;
    total++; if (sc !== 0) $display("FAIL conf_s got %0d want 0", sc); else passed++;
    total++; if (qv[10] !== 1'b0) $display("FAIL conf_q got %b want 0", qv[10]); else passed++;
    set_in = 1'b0;
    reset_in = 1'b0;
    step(12);
  endtask

  task automatic test_back_to_back();
    int sc = 0, rc = 0, ov = 0, first_r = 0;
    set_in = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      sv[i] = s; rv[i] = r; qv[i] = q_exp;
      if (i == 8) reset_in = 1'b1;
      sc += int'(s);
      rc += int'(r);
      ov += int'(s & r);
      if (r && first_r == 0) first_r = i;
    end
    total++; if ({sv[8], sv[9]} !== 2'b11 || sc !== 2) $display("FAIL b2b_s got %b%b count=%0d want 11 2", sv[8], sv[9], sc); else passed++;
    total++; if ({sv[10], rv[10]} !== 2'b00) $display("FAIL b2b_gap got %b%b want 00", sv[10], rv[10]); else passed++;
    total++; if (first_r !== 16 || rc !== 2) $display("FAIL b2b_r got first=%0d count=%0d want 16 2", first_r, rc); else passed++;
    total++; if (ov !== 0) $display("FAIL b2b_overlap got %0d want 0", ov); else passed++;
    total++; if ({qv[11], qv[18]} !== 2'b10) $display("FAIL b2b_q got %b%b want 10", qv[11], qv[18]); else passed++;
    set_in = 1'b0;
    reset_in = 1'b0;
    step(12);
  endtask

  task automatic test_reset_mid_pulse();
    set_in = 1'b1;
    step(9);
    total++; if (s !== 1'b1) $display("FAIL mid_pulse_s got %b want 1", s); else passed++;
    rst = 1'b1;
    set_in = 1'b0;
    step();
    total++; if ({s, r, q_exp, busy} !== 4'b0001) $display("FAIL mid_rst got s%b r%b q%b b%b want 0001", s, r, q_exp, busy); else passed++;
    rst = 1'b0;
    record(4);
    total++; if ({rv[1], rv[2], rv[3]} !== 3'b110) $display("FAIL mid_init_r got %b%b%b want 110", rv[1], rv[2], rv[3]); else passed++;
    total++; if ({bv[4], qv[4], sv[4]} !== 3'b000) $display("FAIL mid_idle got b%b q%b s%b want 000", bv[4], qv[4], sv[4]); else passed++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_glitch();
    test_set();
    test_conflict();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
